reservation_station_param: RTL and testbench



---
 rtl/reservation_station_param_if.sv | 54 +++++
 rtl/reservation_station_param.sv | 166 ++++++++++++++++
 tb/tb_reservation_station_param.sv | 375 +++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/reservation_station_param_if.sv
// Dispatch / issue / forwarding bundle for reservation_station_param.
//   slave  : the reservation station (accepts dispatch, snoops buses, issues).
//   master : the surrounding pipeline (dispatch, result buses, functional unit).
// Signals:
//   inValid/inReady            dispatch handshake
//   inOp, inRob                operation code and destination ROB tag
//   inPendA/B, inTagA/B        operand still waiting, and its producer tag
//   inValA/B                   operand values (ignored while pending)
//   fwdValid/fwdTag/fwdData    NUM_FWD packed result-forwarding buses
//   outValid/outReady          issue handshake to the functional unit
//   outOp, outRob, outValA/B   presented operation
//   count                      registered occupancy
interface reservation_station_param_if #(
  parameter int DEPTH   = 8,
  parameter int NUM_FWD = 4,
  parameter int DATA_W  = 16,
  parameter int TAG_W   = 6,
  parameter int OP_W    = 4
);
  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic                      inValid;
  logic                      inReady;
  logic [OP_W-1:0]           inOp;
  logic [TAG_W-1:0]          inRob;
  logic                      inPendA;
  logic                      inPendB;
  logic [TAG_W-1:0]          inTagA;
  logic [TAG_W-1:0]          inTagB;
  logic [DATA_W-1:0]         inValA;
  logic [DATA_W-1:0]         inValB;
  logic [NUM_FWD-1:0]        fwdValid;
  logic [NUM_FWD*TAG_W-1:0]  fwdTag;
  logic [NUM_FWD*DATA_W-1:0] fwdData;
  logic                      outValid;
  logic                      outReady;
  logic [OP_W-1:0]           outOp;
  logic [TAG_W-1:0]          outRob;
  logic [DATA_W-1:0]         outValA;
  logic [DATA_W-1:0]         outValB;
  logic [CNT_W-1:0]          count;

  modport master (
    output inValid, inOp, inRob, inPendA, inPendB, inTagA, inTagB, inValA, inValB,
    output fwdValid, fwdTag, fwdData, outReady,
    input  inReady, outValid, outOp, outRob, outValA, outValB, count
  );

  modport slave (
    input  inValid, inOp, inRob, inPendA, inPendB, inTagA, inTagB, inValA, inValB,
    input  fwdValid, fwdTag, fwdData, outReady,
    output inReady, outValid, outOp, outRob, outValA, outValB, count
  );
endinterface

// File: rtl/reservation_station_param.sv
// Parametrised reservation station. Holds up to DEPTH renamed operations,
// wakes pending operands from NUM_FWD forwarding buses (also at insert time),
// and issues the oldest ready entry over a valid/ready handshake. A stalled
// issue stays locked on its entry until accepted or flushed.
// Ports:
//   clk     rising-edge clock
//   resetN  asynchronous active-low reset (control state only)
//   flush   synchronous clear of all entries; masks outValid combinationally
//   rs      slave side of reservation_station_param_if (dispatch, buses, issue)
module reservation_station_param #(
  parameter int DEPTH   = 8,
  parameter int NUM_FWD = 4,
  parameter int DATA_W  = 16,
  parameter int TAG_W   = 6,
  parameter int OP_W    = 4
) (
  input  logic                        clk,
  input  logic                        resetN,
  input  logic                        flush,
  reservation_station_param_if.slave  rs
);
  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH) + 1;

  // Returns {hit, data}; the lowest-numbered matching bus wins.
  function automatic logic [DATA_W:0] fwd_match(
    input logic [TAG_W-1:0]          tag,
    input logic [NUM_FWD-1:0]        fv,
    input logic [NUM_FWD*TAG_W-1:0]  ft,
    input logic [NUM_FWD*DATA_W-1:0] fd
  );
    logic [DATA_W:0] r;
    r = '0;
    for (int k = NUM_FWD - 1; k >= 0; k--) begin
      if (fv[k] && (ft[k*TAG_W +: TAG_W] == tag)) r = {1'b1, fd[k*DATA_W +: DATA_W]};
    end
    return r;
  endfunction

  // Control state (reset)
  logic [DEPTH-1:0]  vld;
  logic              lock_vld;
  logic [IDX_W-1:0]  lock_idx;
  logic [CNT_W-1:0]  cnt;

  // Payload state (no reset; only meaningful where vld is set)
  logic [OP_W-1:0]   op_q   [DEPTH];
  logic [TAG_W-1:0]  rob_q  [DEPTH];
  logic [TAG_W-1:0]  ta_q   [DEPTH];
  logic [TAG_W-1:0]  tb_q   [DEPTH];
  logic [DATA_W-1:0] va_q   [DEPTH];
  logic [DATA_W-1:0] vb_q   [DEPTH];
  logic [DEPTH-1:0]  pa_q;
  logic [DEPTH-1:0]  pb_q;
  // older_q[i][j] = 1 when entry j was inserted before entry i.
  logic [DEPTH-1:0]  older_q [DEPTH];

  logic [DEPTH-1:0]  rdy;
  logic              any_rdy;
  logic [IDX_W-1:0]  old_idx;
  logic [IDX_W-1:0]  free_idx;
  logic [IDX_W-1:0]  sel_idx;
  logic              out_vld;
  logic              in_rdy;
  logic              do_ins;
  logic              do_acc;
  logic [DATA_W:0]   cap_a;
  logic [DATA_W:0]   cap_b;
  logic [DATA_W:0]   wk_a [DEPTH];
  logic [DATA_W:0]   wk_b [DEPTH];

  assign rdy = vld & ~pa_q & ~pb_q;

  // Oldest ready entry: the one with no older ready entry.
  always_comb begin
    any_rdy = 1'b0;
    old_idx = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (rdy[i] && ((older_q[i] & rdy) == '0)) begin
        any_rdy = 1'b1;
        old_idx = IDX_W'(i);
      end
    end
  end

  always_comb begin
    free_idx = '0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (!vld[i]) free_idx = IDX_W'(i);
    end
  end

  always_comb begin
    cap_a = fwd_match(rs.inTagA, rs.fwdValid, rs.fwdTag, rs.fwdData);
    cap_b = fwd_match(rs.inTagB, rs.fwdValid, rs.fwdTag, rs.fwdData);
    for (int i = 0; i < DEPTH; i++) begin
      wk_a[i] = fwd_match(ta_q[i], rs.fwdValid, rs.fwdTag, rs.fwdData);
      wk_b[i] = fwd_match(tb_q[i], rs.fwdValid, rs.fwdTag, rs.fwdData);
    end
  end

  // A locked entry stays ready: its operands were already captured.
  assign sel_idx = lock_vld ? lock_idx : old_idx;
  assign out_vld = !flush && (lock_vld || any_rdy);
  assign in_rdy  = (cnt < CNT_W'(DEPTH));
  assign do_ins  = rs.inValid && in_rdy && !flush;
  assign do_acc  = out_vld && rs.outReady;

  assign rs.inReady  = in_rdy;
  assign rs.outValid = out_vld;
  assign rs.outOp    = op_q[sel_idx];
  assign rs.outRob   = rob_q[sel_idx];
  assign rs.outValA  = va_q[sel_idx];
  assign rs.outValB  = vb_q[sel_idx];
  assign rs.count    = cnt;

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      vld      <= '0;
      lock_vld <= 1'b0;
      lock_idx <= '0;
      cnt      <= '0;
    end else if (flush) begin
      vld      <= '0;
      lock_vld <= 1'b0;
      cnt      <= '0;
    end else begin
      if (do_acc) vld[sel_idx]  <= 1'b0;
      if (do_ins) vld[free_idx] <= 1'b1;
      if (do_acc) begin
        lock_vld <= 1'b0;
      end else if (out_vld) begin
        lock_vld <= 1'b1;
        lock_idx <= sel_idx;
      end
      cnt <= cnt + CNT_W'(do_ins) - CNT_W'(do_acc);
    end
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < DEPTH; i++) begin
      if (vld[i] && pa_q[i] && wk_a[i][DATA_W]) begin
        pa_q[i] <= 1'b0;
        va_q[i] <= wk_a[i][DATA_W-1:0];
      end
      if (vld[i] && pb_q[i] && wk_b[i][DATA_W]) begin
        pb_q[i] <= 1'b0;
        vb_q[i] <= wk_b[i][DATA_W-1:0];
      end
    end
    if (do_ins) begin
      op_q[free_idx]  <= rs.inOp;
      rob_q[free_idx] <= rs.inRob;
      ta_q[free_idx]  <= rs.inTagA;
      tb_q[free_idx]  <= rs.inTagB;
      pa_q[free_idx]  <= rs.inPendA && !cap_a[DATA_W];
      pb_q[free_idx]  <= rs.inPendB && !cap_b[DATA_W];
      va_q[free_idx]  <= (rs.inPendA && cap_a[DATA_W]) ? cap_a[DATA_W-1:0] : rs.inValA;
      vb_q[free_idx]  <= (rs.inPendB && cap_b[DATA_W]) ? cap_b[DATA_W-1:0] : rs.inValB;
      // Everything currently held is older than the newcomer; stale bits
      // toward freed slots are cleared when those slots are refilled.
      older_q[free_idx] <= vld;
      for (int i = 0; i < DEPTH; i++) older_q[i][free_idx] <= 1'b0;
    end
  end
endmodule

// File: tb/tb_reservation_station_param.sv
`timescale 1ns/1ps
module tb_reservation_station_param;
  localparam int DEPTH   = 8;
  localparam int NUM_FWD = 4;
  localparam int DATA_W  = 16;
  localparam int TAG_W   = 6;
  localparam int OP_W    = 4;

  logic clk = 1'b0;
  logic resetN;
  logic flush;
  int   n_chk  = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;

  reservation_station_param_if #(.DEPTH(DEPTH), .NUM_FWD(NUM_FWD), .DATA_W(DATA_W),
                                 .TAG_W(TAG_W), .OP_W(OP_W)) rs();

  reservation_station_param #(.DEPTH(DEPTH), .NUM_FWD(NUM_FWD), .DATA_W(DATA_W),
                              .TAG_W(TAG_W), .OP_W(OP_W)) dut (
    .clk(clk), .resetN(resetN), .flush(flush), .rs(rs)
  );

  // ---------------- behavioural reference model ----------------
  typedef struct {
    logic [OP_W-1:0]   op;
    logic [TAG_W-1:0]  rob;
    bit                pa, pb;
    logic [TAG_W-1:0]  ta, tb;
    logic [DATA_W-1:0] va, vb;
    int                id;
  } ment_t;

  ment_t mq[$];          // entries in insertion order, oldest first
  bit    m_lock = 1'b0;
  int    m_lock_id = 0;
  int    next_id = 0;

  function automatic void fwd_find(input logic [TAG_W-1:0] tag, output bit hit,
                                   output logic [DATA_W-1:0] d);
    hit = 1'b0;
    d   = '0;
    for (int k = 0; k < NUM_FWD; k++) begin
      if (!hit && rs.fwdValid[k] && rs.fwdTag[k*TAG_W +: TAG_W] == tag) begin
        hit = 1'b1;
        d   = rs.fwdData[k*DATA_W +: DATA_W];
      end
    end
  endfunction

  function automatic void model_present(output bit pv, output int pidx);
    pidx = -1;
    for (int i = 0; i < mq.size(); i++) begin
      if (m_lock) begin
        if (mq[i].id == m_lock_id) pidx = i;
      end else if (pidx < 0 && !mq[i].pa && !mq[i].pb) begin
        pidx = i;
      end
    end
    pv = (pidx >= 0) && !flush;
  endfunction

  function automatic void model_update(input bit pv, input int pidx);
    int    n_before;
    bit    hit;
    logic [DATA_W-1:0] d;
    ment_t e;
    if (flush) begin
      mq.delete();
      m_lock = 1'b0;
      return;
    end
    n_before = mq.size();
    if (pv && rs.outReady) begin
      mq.delete(pidx);
      m_lock = 1'b0;
    end else if (pv) begin
      m_lock    = 1'b1;
      m_lock_id = mq[pidx].id;
    end
    for (int i = 0; i < mq.size(); i++) begin
      if (mq[i].pa) begin
        fwd_find(mq[i].ta, hit, d);
        if (hit) begin mq[i].pa = 1'b0; mq[i].va = d; end
      end
      if (mq[i].pb) begin
        fwd_find(mq[i].tb, hit, d);
        if (hit) begin mq[i].pb = 1'b0; mq[i].vb = d; end
      end
    end
    if (rs.inValid && n_before < DEPTH) begin
      e.op = rs.inOp; e.rob = rs.inRob; e.ta = rs.inTagA; e.tb = rs.inTagB;
      e.pa = rs.inPendA; e.pb = rs.inPendB; e.va = rs.inValA; e.vb = rs.inValB;
      e.id = next_id;
      next_id++;
      if (e.pa) begin
        fwd_find(e.ta, hit, d);
        if (hit) begin e.pa = 1'b0; e.va = d; end
      end
      if (e.pb) begin
        fwd_find(e.tb, hit, d);
        if (hit) begin e.pb = 1'b0; e.vb = d; end
      end
      mq.push_back(e);
    end
  endfunction

  // ---------------- helpers ----------------
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic idle_in();
    rs.inValid = 1'b0; rs.inOp = '0; rs.inRob = '0;
    rs.inPendA = 1'b0; rs.inPendB = 1'b0; rs.inTagA = '0; rs.inTagB = '0;
    rs.inValA = '0; rs.inValB = '0;
    rs.fwdValid = '0; rs.fwdTag = '0; rs.fwdData = '0;
    rs.outReady = 1'b0;
    flush = 1'b0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic offer(input logic [TAG_W-1:0] rob, input bit pa, input logic [TAG_W-1:0] ta,
                       input logic [DATA_W-1:0] va, input bit pb, input logic [TAG_W-1:0] tb,
                       input logic [DATA_W-1:0] vb);
    rs.inValid = 1'b1; rs.inOp = rob[OP_W-1:0]; rs.inRob = rob;
    rs.inPendA = pa; rs.inTagA = ta; rs.inValA = va;
    rs.inPendB = pb; rs.inTagB = tb; rs.inValB = vb;
  endtask

  task automatic offer_rdy(input logic [TAG_W-1:0] rob);
    offer(rob, 1'b0, '0, 16'hA000 | 16'(rob), 1'b0, '0, 16'hB000 | 16'(rob));
  endtask

  task automatic set_fwd(input int k, input logic [TAG_W-1:0] tag, input logic [DATA_W-1:0] data);
    rs.fwdValid[k] = 1'b1;
    rs.fwdTag[k*TAG_W +: TAG_W] = tag;
    rs.fwdData[k*DATA_W +: DATA_W] = data;
  endtask

  task automatic do_flush();
    idle_in();
    flush = 1'b1;
    #1;
    chk("flush_outValid", 32'(rs.outValid), 32'd0);
    step();
    flush = 1'b0;
    #1;
    chk("flush_count", 32'(rs.count), 32'd0);
  endtask

  typedef struct {
    bit               v;
    logic [TAG_W-1:0] rob;
    bit               ordy;
    bit               e_ovld;
    bit               e_irdy;
    int               e_cnt;
    logic [TAG_W-1:0] e_orob;
  } vec_t;

  vec_t tbl[13];

  initial begin
    #2_000_000;
    $display("FAIL watchdog: time limit reached, expected $finish earlier");
    $fatal(1, "watchdog");
  end

  initial begin
    bit pv;
    int pidx;

    for (int k = 0; k < 9; k++)
      tbl[k] = '{v: 1'b1, rob: 6'(k + 1), ordy: 1'b0, e_ovld: (k > 0), e_irdy: (k < 8),
                 e_cnt: k, e_orob: 6'd1};
    tbl[9]  = '{v: 1'b0, rob: 6'd0,  ordy: 1'b0, e_ovld: 1'b1, e_irdy: 1'b0, e_cnt: 8, e_orob: 6'd1};
    tbl[10] = '{v: 1'b1, rob: 6'd20, ordy: 1'b1, e_ovld: 1'b1, e_irdy: 1'b0, e_cnt: 8, e_orob: 6'd1};
    tbl[11] = '{v: 1'b0, rob: 6'd0,  ordy: 1'b1, e_ovld: 1'b1, e_irdy: 1'b1, e_cnt: 7, e_orob: 6'd2};
    tbl[12] = '{v: 1'b0, rob: 6'd0,  ordy: 1'b1, e_ovld: 1'b1, e_irdy: 1'b1, e_cnt: 6, e_orob: 6'd3};

    idle_in();
    resetN = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    resetN = 1'b1;
    #1;
    chk("reset_outValid", 32'(rs.outValid), 32'd0);
    chk("reset_inReady", 32'(rs.inReady), 32'd1);
    chk("reset_count", 32'(rs.count), 32'd0);
    step();

    // fill to full, refused ninth offer, drain with a refused insert while full
    for (int r = 0; r < 13; r++) begin
      idle_in();
      if (tbl[r].v) offer_rdy(tbl[r].rob);
      rs.outReady = tbl[r].ordy;
      #1;
      chk("tbl_outValid", 32'(rs.outValid), 32'(tbl[r].e_ovld));
      chk("tbl_inReady", 32'(rs.inReady), 32'(tbl[r].e_irdy));
      chk("tbl_count", 32'(rs.count), 32'(tbl[r].e_cnt));
      if (tbl[r].e_ovld) begin
        chk("tbl_outRob", 32'(rs.outRob), 32'(tbl[r].e_orob));
        chk("tbl_outOp", 32'(rs.outOp), 32'(tbl[r].e_orob[OP_W-1:0]));
        chk("tbl_outValA", 32'(rs.outValA), 32'(16'hA000 | 16'(tbl[r].e_orob)));
      end
      step();
    end
    do_flush();

    // age order: younger ready entry issues before older pending one
    idle_in(); offer(6'd5, 1'b1, 6'd9, 16'hDEAD, 1'b0, '0, 16'h0005); #1;
    chk("age_empty_outValid", 32'(rs.outValid), 32'd0);
    step();
    idle_in(); offer_rdy(6'd6); #1;
    chk("age_pend_outValid", 32'(rs.outValid), 32'd0);
    chk("age_count1", 32'(rs.count), 32'd1);
    step();
    idle_in(); set_fwd(0, 6'd9, 16'h1234); rs.outReady = 1'b1; #1;
    chk("age_first_rob", 32'(rs.outRob), 32'd6);
    step();
    idle_in(); rs.outReady = 1'b1; #1;
    chk("age_second_rob", 32'(rs.outRob), 32'd5);
    chk("age_second_valA", 32'(rs.outValA), 32'h1234);
    chk("age_second_valB", 32'(rs.outValB), 32'h0005);
    step();
    idle_in(); #1;
    chk("age_drained_outValid", 32'(rs.outValid), 32'd0);
    chk("age_drained_count", 32'(rs.count), 32'd0);

    // same-cycle capture at insert; an invalid bus with a matching tag is ignored
    idle_in(); offer(6'h21, 1'b0, '0, 16'h1111, 1'b1, 6'd3, 16'h0BAD);
    set_fwd(2, 6'd3, 16'hBEEF);
    rs.fwdTag[1*TAG_W +: TAG_W] = 6'd3; rs.fwdData[1*DATA_W +: DATA_W] = 16'hDEAD;
    step();
    idle_in(); #1;
    chk("cap_outValid", 32'(rs.outValid), 32'd1);
    chk("cap_outRob", 32'(rs.outRob), 32'h21);
    chk("cap_outValB", 32'(rs.outValB), 32'hBEEF);
    chk("cap_outValA", 32'(rs.outValA), 32'h1111);
    rs.outReady = 1'b1;
    step();
    idle_in(); #1;
    chk("cap_drained_count", 32'(rs.count), 32'd0);

    // lock: stalled rob 7 holds even after older rob 8 wakes
    idle_in(); offer(6'd8, 1'b1, 6'd12, 16'h0000, 1'b0, '0, 16'h0008); step();
    idle_in(); offer_rdy(6'd7); step();
    idle_in(); set_fwd(1, 6'd12, 16'h00C8); #1;
    chk("lock_first_rob", 32'(rs.outRob), 32'd7);
    step();
    idle_in();
    for (int i = 0; i < 5; i++) begin
      #1;
      chk("lock_hold_valid", 32'(rs.outValid), 32'd1);
      chk("lock_hold_rob", 32'(rs.outRob), 32'd7);
      chk("lock_hold_valA", 32'(rs.outValA), 32'hA007);
      step();
    end
    rs.outReady = 1'b1; #1;
    chk("lock_accept_rob", 32'(rs.outRob), 32'd7);
    step();
    #1;
    chk("lock_next_rob", 32'(rs.outRob), 32'd8);
    chk("lock_next_valA", 32'(rs.outValA), 32'h00C8);
    step();
    idle_in(); #1;
    chk("lock_drained_count", 32'(rs.count), 32'd0);

    // simultaneous insert+accept at count 4; bus priority on duplicate tag
    for (int i = 0; i < 4; i++) begin
      idle_in(); offer_rdy(6'(8'h31 + i)); step();
    end
    idle_in(); offer_rdy(6'h35); rs.outReady = 1'b1; #1;
    chk("simul_count_before", 32'(rs.count), 32'd4);
    chk("simul_rob_31", 32'(rs.outRob), 32'h31);
    step();
    #1;
    chk("simul_count_after", 32'(rs.count), 32'd4);
    idle_in(); offer(6'h36, 1'b1, 6'd11, 16'h0000, 1'b0, '0, 16'h0036); rs.outReady = 1'b1; #1;
    chk("simul_rob_32", 32'(rs.outRob), 32'h32);
    step();
    idle_in(); rs.outReady = 1'b1;
    set_fwd(0, 6'd11, 16'h0001); set_fwd(3, 6'd11, 16'h0002); #1;
    chk("prio_count", 32'(rs.count), 32'd4);
    chk("prio_rob_33", 32'(rs.outRob), 32'h33);
    step();
    idle_in(); rs.outReady = 1'b1; #1;
    chk("prio_rob_34", 32'(rs.outRob), 32'h34);
    step(); #1;
    chk("prio_rob_35", 32'(rs.outRob), 32'h35);
    step(); #1;
    chk("prio_rob_36", 32'(rs.outRob), 32'h36);
    chk("prio_valA", 32'(rs.outValA), 32'h0001);
    step(); #1;
    chk("prio_drained_count", 32'(rs.count), 32'd0);
    chk("prio_drained_outValid", 32'(rs.outValid), 32'd0);

    // flush with 6 entries and a concurrent insert/accept
    for (int i = 0; i < 6; i++) begin
      idle_in(); offer_rdy(6'(8'h41 + i)); step();
    end
    idle_in(); #1;
    chk("flush6_count_before", 32'(rs.count), 32'd6);
    offer_rdy(6'h47); rs.outReady = 1'b1; flush = 1'b1; #1;
    chk("flush6_outValid", 32'(rs.outValid), 32'd0);
    step();
    idle_in(); rs.outReady = 1'b1; #1;
    chk("flush6_count_after", 32'(rs.count), 32'd0);
    for (int i = 0; i < 3; i++) begin
      chk("flush6_no_issue", 32'(rs.outValid), 32'd0);
      step();
    end

    // asynchronous reset during a stall
    idle_in(); offer_rdy(6'h51); step();
    idle_in(); #1;
    chk("areset_pre_outValid", 32'(rs.outValid), 32'd1);
    step();
    #1; resetN = 1'b0; #1;
    chk("areset_outValid", 32'(rs.outValid), 32'd0);
    chk("areset_inReady", 32'(rs.inReady), 32'd1);
    chk("areset_count", 32'(rs.count), 32'd0);
    resetN = 1'b1;
    step();

    // randomized traffic against the reference model
    mq.delete();
    m_lock = 1'b0;
    for (int c = 0; c < 3000; c++) begin
      rs.inValid  = ($urandom_range(0, 9) < 6);
      rs.inOp     = 4'($urandom);
      rs.inRob    = 6'($urandom);
      rs.inPendA  = 1'($urandom_range(0, 1));
      rs.inPendB  = 1'($urandom_range(0, 1));
      rs.inTagA   = 6'($urandom_range(0, 7));
      rs.inTagB   = 6'($urandom_range(0, 7));
      rs.inValA   = 16'($urandom);
      rs.inValB   = 16'($urandom);
      for (int k = 0; k < NUM_FWD; k++) begin
        rs.fwdValid[k] = ($urandom_range(0, 3) == 0);
        rs.fwdTag[k*TAG_W +: TAG_W] = 6'($urandom_range(0, 7));
        rs.fwdData[k*DATA_W +: DATA_W] = 16'($urandom);
      end
      rs.outReady = 1'($urandom_range(0, 1));
      flush       = ($urandom_range(0, 63) == 0);
      #1;
      model_present(pv, pidx);
      chk("rnd_outValid", 32'(rs.outValid), 32'(pv));
      chk("rnd_count", 32'(rs.count), 32'(mq.size()));
      chk("rnd_inReady", 32'(rs.inReady), 32'(mq.size() < DEPTH));
      if (pv) begin
        chk("rnd_outRob", 32'(rs.outRob), 32'(mq[pidx].rob));
        chk("rnd_outOp", 32'(rs.outOp), 32'(mq[pidx].op));
        chk("rnd_outValA", 32'(rs.outValA), 32'(mq[pidx].va));
        chk("rnd_outValB", 32'(rs.outValB), 32'(mq[pidx].vb));
      end
      model_update(pv, pidx);
      step();
    end

    idle_in();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
